// File: rtl/hwpe_stream_word_packer.sv
// Packs NB_WORDS narrow stream words into one wide beat. Transfers are
// nb_words_i long, and a partial final beat is zero-filled in its unused lanes.
module hwpe_stream_word_packer #(
  parameter int unsigned DATA_WIDTH_IN = 32,
  parameter int unsigned NB_WORDS      = 4,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    clear_i,
  input  logic [DATA_WIDTH_IN-1:0]                push_data_i,
  input  logic [DATA_WIDTH_IN/8-1:0]              push_strb_i,
  input  logic                                    push_valid_i,
  output logic                                    push_ready_o,
  output logic [NB_WORDS*DATA_WIDTH_IN-1:0]       pop_data_o,
  output logic [NB_WORDS*DATA_WIDTH_IN/8-1:0]     pop_strb_o,
  output logic                                    pop_valid_o,
  input  logic                                    pop_ready_i,
  input  logic                                    start_i,
  input  logic [CNT_WIDTH-1:0]                    nb_words_i,
  output logic                                    ready_start_o,
  output logic                                    done_o
);

  localparam int unsigned STRB_IN   = DATA_WIDTH_IN / 8;
  localparam int unsigned DATA_OUT  = NB_WORDS * DATA_WIDTH_IN;
  localparam int unsigned STRB_OUT  = NB_WORDS * STRB_IN;
  localparam int unsigned IDX_W     = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_WORDS - 1);

  typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_WIDTH-1:0]   rem_q, rem_d;
  logic [DATA_OUT-1:0]    acc_data_q, acc_data_d;
  logic [STRB_OUT-1:0]    acc_strb_q, acc_strb_d;
  logic [DATA_OUT-1:0]    out_data_q, out_data_d;
  logic [STRB_OUT-1:0]    out_strb_q, out_strb_d;
  logic                   out_valid_q, out_valid_d;
  logic                   done_q, done_d;

  logic                   completing;
  logic                   last_word;
  logic                   push_hs;
  logic                   pop_hs;
  logic [DATA_OUT-1:0]    merged_data;
  logic [STRB_OUT-1:0]    merged_strb;

  // A word closes a beat when it fills the top lane or is the last of the transfer.
  assign last_word  = (rem_q == CNT_WIDTH'(1));
  assign completing = (idx_q == LAST_IDX) || last_word;
  assign push_hs    = push_valid_i && push_ready_o;
  assign pop_hs     = out_valid_q && pop_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i && (nb_words_i != '0)) state_d = PACK;
      PACK:    if (push_hs && last_word)          state_d = DRAIN;
      DRAIN:   if (pop_hs)                        state_d = IDLE;
      default:                                    state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  // The closing word may only enter when the output register is free or emptying.
  always_comb begin
    ready_start_o = (state_q == IDLE);
    push_ready_o  = 1'b0;
    if (state_q == PACK) begin
      push_ready_o = !completing || !out_valid_q || pop_ready_i;
    end
  end

  always_comb begin
    merged_data = acc_data_q;
    merged_strb = acc_strb_q;
    for (int l = 0; l < int'(NB_WORDS); l++) begin
      if (idx_q == IDX_W'(l)) begin
        merged_data[l*DATA_WIDTH_IN +: DATA_WIDTH_IN] = push_data_i;
        merged_strb[l*STRB_IN +: STRB_IN]             = push_strb_i;
      end
    end
  end

  always_comb begin
    idx_d       = idx_q;
    rem_d       = rem_q;
    acc_data_d  = acc_data_q;
    acc_strb_d  = acc_strb_q;
    out_data_d  = out_data_q;
    out_strb_d  = out_strb_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;

    if ((state_q == IDLE) && start_i) begin
      if (nb_words_i != '0) begin
        rem_d      = nb_words_i;
        idx_d      = '0;
        acc_data_d = '0;
        acc_strb_d = '0;
      end else begin
        done_d = 1'b1;
      end
    end

    // Output register reads as zero whenever it holds no beat.
    if (pop_hs) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_strb_d  = '0;
    end

    if (push_hs) begin
      if (rem_q != '0) rem_d = rem_q - CNT_WIDTH'(1);
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      if (completing) begin
        out_data_d  = merged_data;
        out_strb_d  = merged_strb;
        out_valid_d = 1'b1;
        acc_data_d  = '0;
        acc_strb_d  = '0;
      end else begin
        acc_data_d = merged_data;
        acc_strb_d = merged_strb;
      end
    end

    if ((state_q == DRAIN) && pop_hs) done_d = 1'b1;

    if (clear_i) begin
      idx_d       = '0;
      rem_d       = '0;
      acc_data_d  = '0;
      acc_strb_d  = '0;
      out_data_d  = '0;
      out_strb_d  = '0;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q       <= '0;
      rem_q       <= '0;
      acc_data_q  <= '0;
      acc_strb_q  <= '0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      acc_data_q  <= acc_data_d;
      acc_strb_q  <= acc_strb_d;
      out_data_q  <= out_data_d;
      out_strb_q  <= out_strb_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign pop_data_o  = out_data_q;
  assign pop_strb_o  = out_strb_q;
  assign pop_valid_o = out_valid_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_hwpe_stream_word_packer.sv
// Self-checking bench for hwpe_stream_word_packer: directed scenarios plus
// randomized transfers compared against a lane-arithmetic reference model.
`timescale 1ns/1ps
module tb_hwpe_stream_word_packer;

  localparam int DW  = 32;
  localparam int NB  = 4;
  localparam int CW  = 16;
  localparam int DO  = DW * NB;
  localparam int SO  = DO / 8;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i = 1'b0;
  logic [DW-1:0] push_data_i = '0;
  logic [3:0]    push_strb_i = '0;
  logic          push_valid_i = 1'b0;
  logic          push_ready_o;
  logic [DO-1:0] pop_data_o;
  logic [SO-1:0] pop_strb_o;
  logic          pop_valid_o;
  logic          pop_ready_i = 1'b0;
  logic          start_i = 1'b0;
  logic [CW-1:0] nb_words_i = '0;
  logic          ready_start_o;
  logic          done_o;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] words [64];
  logic [3:0]    strbs [64];
  int            accept_cyc [64];
  logic [DO-1:0] got_data [$];
  logic [SO-1:0] got_strb [$];
  int            pop_cyc [$];
  int            done_cnt, done_cyc, stall_err, idle_err;
  bit            timed_out;

  hwpe_stream_word_packer #(.DATA_WIDTH_IN(DW), .NB_WORDS(NB), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .push_data_i(push_data_i), .push_strb_i(push_strb_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .pop_data_o(pop_data_o), .pop_strb_o(pop_strb_o),
    .pop_valid_o(pop_valid_o), .pop_ready_i(pop_ready_i),
    .start_i(start_i), .nb_words_i(nb_words_i),
    .ready_start_o(ready_start_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  // Beat b holds words b*NB .. b*NB+NB-1, lane 0 lowest; words past n are zero.
  function automatic logic [DO-1:0] model_data(int b, int n);
    logic [DO-1:0] r = '0;
    for (int l = 0; l < NB; l++)
      if (b*NB + l < n) r[l*DW +: DW] = words[b*NB + l];
    return r;
  endfunction

  function automatic logic [SO-1:0] model_strb(int b, int n);
    logic [SO-1:0] r = '0;
    for (int l = 0; l < NB; l++)
      if (b*NB + l < n) r[l*4 +: 4] = strbs[b*NB + l];
    return r;
  endfunction

  task automatic run_transfer(input int n, input int hold, input int vprob,
                              input int rprob, input int inj_cyc);
    int ptr = 0;
    int cyc = 0;
    int post = -1;
    bit prev_stall = 0;
    logic [DO-1:0] prev_data = '0;
    logic [SO-1:0] prev_strb = '0;
    got_data.delete(); got_strb.delete(); pop_cyc.delete();
    for (int i = 0; i < 64; i++) accept_cyc[i] = -1;
    done_cnt = 0; done_cyc = -1; stall_err = 0; idle_err = 0;
    @(negedge clk_i);
    start_i = 1'b1; nb_words_i = CW'(n);
    @(negedge clk_i);
    start_i = 1'b0; nb_words_i = '0;
    while (cyc < 400) begin
      push_valid_i = (ptr < n) && ($urandom_range(99) < vprob);
      push_data_i  = words[ptr];
      push_strb_i  = strbs[ptr];
      pop_ready_i  = (cyc >= hold) && ($urandom_range(99) < rprob);
      start_i      = (cyc == inj_cyc);
      nb_words_i   = (cyc == inj_cyc) ? CW'(100) : '0;
      #1;
      if (prev_stall && (pop_valid_o !== 1'b1 || pop_data_o !== prev_data || pop_strb_o !== prev_strb))
        stall_err++;
      if (!pop_valid_o && (pop_data_o !== '0 || pop_strb_o !== '0)) idle_err++;
      if (done_o) begin done_cnt++; done_cyc = cyc; end
      if (pop_valid_o && pop_ready_i) begin
        got_data.push_back(pop_data_o);
        got_strb.push_back(pop_strb_o);
        pop_cyc.push_back(cyc);
      end
      if (push_valid_i && push_ready_o) begin accept_cyc[ptr] = cyc; ptr++; end
      prev_stall = pop_valid_o && !pop_ready_i;
      prev_data  = pop_data_o;
      prev_strb  = pop_strb_o;
      if (done_cnt > 0 && post < 0) post = cyc;
      if (post >= 0 && cyc >= post + 3) break;
      @(negedge clk_i);
      cyc++;
    end
    timed_out = (post < 0);
    push_valid_i = 1'b0; pop_ready_i = 1'b0; start_i = 1'b0; nb_words_i = '0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    total++; if (ready_start_o !== 1'b1) begin bad++; $display("FAIL reset_ready_start got=%b want=1", ready_start_o); end
    total++; if (push_ready_o !== 1'b0) begin bad++; $display("FAIL reset_push_ready got=%b want=0", push_ready_o); end
    total++; if (pop_valid_o !== 1'b0 || pop_data_o !== '0) begin bad++; $display("FAIL reset_pop got=%b/%h want=0/0", pop_valid_o, pop_data_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done_o); end
    @(negedge clk_i); rst_ni = 1'b1;
    // Fill one beat with pop stalled, then reset between clock edges.
    @(negedge clk_i); start_i = 1'b1; nb_words_i = CW'(4);
    @(negedge clk_i); start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_valid_i = 1'b1; push_data_i = 32'hC0 + i; push_strb_i = 4'hF;
      @(negedge clk_i);
    end
    push_valid_i = 1'b0;
    #1;
    total++; if (pop_valid_o !== 1'b1) begin bad++; $display("FAIL prereset_beat got=%b want=1", pop_valid_o); end
    rst_ni = 1'b0;
    #1;
    total++; if (pop_valid_o !== 1'b0 || ready_start_o !== 1'b1) begin bad++; $display("FAIL async_reset got=%b/%b want=0/1", pop_valid_o, ready_start_o); end
    @(negedge clk_i); rst_ni = 1'b1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin words[i] = 32'(i + 1); strbs[i] = 4'hF; end
    run_transfer(8, 0, 100, 100, -1);
    total++; if (timed_out) begin bad++; $display("FAIL b2b_timeout got=timeout want=done"); end
    total++; if (got_data.size() != 2) begin bad++; $display("FAIL b2b_beats got=%0d want=2", got_data.size()); end
    if (got_data.size() == 2) begin
      total++; if (got_data[0] !== 128'h00000004_00000003_00000002_00000001) begin bad++; $display("FAIL b2b_beat0 got=%h", got_data[0]); end
      total++; if (got_data[1] !== 128'h00000008_00000007_00000006_00000005) begin bad++; $display("FAIL b2b_beat1 got=%h", got_data[1]); end
      total++; if (got_strb[0] !== 16'hFFFF || got_strb[1] !== 16'hFFFF) begin bad++; $display("FAIL b2b_strb got=%h/%h want=ffff", got_strb[0], got_strb[1]); end
      total++; if (pop_cyc[0] !== accept_cyc[3] + 1) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", pop_cyc[0], accept_cyc[3] + 1); end
      total++; if (done_cyc !== pop_cyc[1] + 1) begin bad++; $display("FAIL b2b_done_cycle got=%0d want=%0d", done_cyc, pop_cyc[1] + 1); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL b2b_done_count got=%0d want=1", done_cnt); end
    total++; if (stall_err != 0 || idle_err != 0) begin bad++; $display("FAIL b2b_hold got=%0d/%0d want=0/0", stall_err, idle_err); end
  endtask

  task automatic test_partial();
    for (int i = 0; i < 6; i++) begin words[i] = 32'(i + 1); strbs[i] = 4'hF; end
    run_transfer(6, 0, 100, 100, -1);
    total++; if (got_data.size() != 2) begin bad++; $display("FAIL partial_beats got=%0d want=2", got_data.size()); end
    if (got_data.size() == 2) begin
      total++; if (got_data[1] !== 128'h00000000_00000000_00000006_00000005) begin bad++; $display("FAIL partial_data got=%h", got_data[1]); end
      total++; if (got_strb[1] !== 16'h00FF) begin bad++; $display("FAIL partial_strb got=%h want=00ff", got_strb[1]); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL partial_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) begin words[i] = $urandom; strbs[i] = 4'hF; end
    run_transfer(8, 20, 100, 100, -1);
    total++; if (accept_cyc[4] != 4 || accept_cyc[5] != 5 || accept_cyc[6] != 6) begin
      bad++; $display("FAIL bp_words5to7 got=%0d,%0d,%0d want=4,5,6", accept_cyc[4], accept_cyc[5], accept_cyc[6]); end
    total++; if (accept_cyc[7] != 20) begin bad++; $display("FAIL bp_word8_blocked got=%0d want=20", accept_cyc[7]); end
    total++; if (got_data.size() != 2) begin bad++; $display("FAIL bp_beats got=%0d want=2", got_data.size()); end
    for (int b = 0; b < got_data.size() && b < 2; b++) begin
      total++; if (got_data[b] !== model_data(b, 8)) begin bad++; $display("FAIL bp_beat%0d got=%h want=%h", b, got_data[b], model_data(b, 8)); end
    end
    total++; if (stall_err != 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", stall_err); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_clear();
    @(negedge clk_i); start_i = 1'b1; nb_words_i = CW'(8);
    @(negedge clk_i); start_i = 1'b0; nb_words_i = '0;
    for (int i = 0; i < 3; i++) begin
      push_valid_i = 1'b1; push_data_i = 32'hE0 + i; push_strb_i = 4'hF;
      @(negedge clk_i);
    end
    // Clear lands together with the beat-closing fourth word.
    clear_i = 1'b1; push_valid_i = 1'b1; push_data_i = 32'hE3; pop_ready_i = 1'b0;
    @(negedge clk_i);
    clear_i = 1'b0; push_valid_i = 1'b0;
    #1;
    total++; if (pop_valid_o !== 1'b0) begin bad++; $display("FAIL clear_pop_valid got=%b want=0", pop_valid_o); end
    total++; if (ready_start_o !== 1'b1) begin bad++; $display("FAIL clear_ready_start got=%b want=1", ready_start_o); end
    for (int c = 0; c < 4; c++) begin
      total++; if (done_o !== 1'b0) begin bad++; $display("FAIL clear_no_done got=%b want=0", done_o); end
      @(negedge clk_i); #1;
    end
    for (int i = 0; i < 4; i++) begin words[i] = 32'hA0 + i; strbs[i] = 4'hF; end
    run_transfer(4, 0, 100, 100, -1);
    total++; if (got_data.size() != 1) begin bad++; $display("FAIL clear_restart_beats got=%0d want=1", got_data.size()); end
    if (got_data.size() == 1) begin
      total++; if (got_data[0] !== 128'h000000A3_000000A2_000000A1_000000A0) begin bad++; $display("FAIL clear_restart_data got=%h", got_data[0]); end
    end
  endtask

  task automatic test_zero_and_ignore();
    @(negedge clk_i); start_i = 1'b1; nb_words_i = '0;
    @(negedge clk_i); start_i = 1'b0;
    #1;
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL zero_done got=%b want=1", done_o); end
    total++; if (pop_valid_o !== 1'b0 || ready_start_o !== 1'b1) begin bad++; $display("FAIL zero_idle got=%b/%b want=0/1", pop_valid_o, ready_start_o); end
    @(negedge clk_i); #1;
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL zero_pulse_width got=%b want=0", done_o); end
    for (int i = 0; i < 4; i++) begin words[i] = $urandom; strbs[i] = 4'hF; end
    run_transfer(4, 0, 100, 100, 2);
    total++; if (timed_out || got_data.size() != 1 || done_cnt != 1) begin
      bad++; $display("FAIL ignore_start got=beats %0d done %0d want=beats 1 done 1", got_data.size(), done_cnt); end
    if (got_data.size() >= 1) begin
      total++; if (got_data[0] !== model_data(0, 4)) begin bad++; $display("FAIL ignore_start_data got=%h want=%h", got_data[0], model_data(0, 4)); end
    end
  endtask

  task automatic test_strb_lane();
    for (int i = 0; i < 4; i++) begin words[i] = $urandom; strbs[i] = 4'hF; end
    strbs[2] = 4'h3;
    run_transfer(4, 0, 100, 100, -1);
    total++; if (got_strb.size() != 1) begin bad++; $display("FAIL strb_beats got=%0d want=1", got_strb.size()); end
    if (got_strb.size() == 1) begin
      total++; if (got_strb[0] !== 16'hF3FF) begin bad++; $display("FAIL strb_lane2 got=%h want=f3ff", got_strb[0]); end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int n = $urandom_range(13, 1);
      for (int i = 0; i < n; i++) begin words[i] = $urandom; strbs[i] = 4'($urandom); end
      run_transfer(n, $urandom_range(5, 0), 70, 60, -1);
      total++; if (timed_out || got_data.size() != (n + NB - 1) / NB) begin
        bad++; $display("FAIL rand%0d_beats got=%0d want=%0d", t, got_data.size(), (n + NB - 1) / NB); end
      for (int b = 0; b < got_data.size() && b < (n + NB - 1) / NB; b++) begin
        total++; if (got_data[b] !== model_data(b, n) || got_strb[b] !== model_strb(b, n)) begin
          bad++; $display("FAIL rand%0d_beat%0d got=%h/%h want=%h/%h", t, b, got_data[b], got_strb[b], model_data(b, n), model_strb(b, n)); end
      end
      total++; if (done_cnt != 1 || stall_err != 0 || idle_err != 0) begin
        bad++; $display("FAIL rand%0d_protocol got=done %0d stall %0d idle %0d want=1 0 0", t, done_cnt, stall_err, idle_err); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_partial();
    test_backpressure();
    test_clear();
    test_zero_and_ignore();
    test_strb_lane();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
